alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with registered result/flag outputs and valid/ready handshakes.
// Define ALU_PIPE_MUL_EN to add an iterative WIDTH-cycle shift-add multiplier on opcode 0110.

module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic             set_cond,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_wr,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             cond_eq,
  output logic             cond_ne,
  output logic             cond_hi,
  output logic             cond_lt
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam int         CNT_W  = $clog2(WIDTH);
`endif
  localparam int MSB = WIDTH - 1;

  logic             r_outValid;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_outTag;
  logic             r_outWr;
  logic             r_n;
  logic             r_z;
  logic             r_c;
  logic             r_v;

  logic             w_isSub;
  logic [WIDTH-1:0] w_addB;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_ovf;
  logic [WIDTH-1:0] w_aluRes;
  logic             w_aluArith;
  logic             w_aluWr;

  logic             w_outFree;
  logic             w_accept;
  logic             w_busy;
  logic             w_load;
  logic [WIDTH-1:0] w_ldRes;
  logic [TAG_W-1:0] w_ldTag;
  logic             w_ldWr;
  logic             w_ldSetCond;
  logic             w_ldArith;

  assign w_outFree = !r_outValid | out_ready;
  assign in_ready  = !w_busy & w_outFree;
  assign w_accept  = in_valid & in_ready;

  // One shared adder serves ADD, SUB and CMP; subtraction is op1 + ~op2 + 1.
  always_comb begin
    w_isSub = (opcode == OP_SUB) || (opcode == OP_CMP);
    w_addB  = w_isSub ? ~op2 : op2;
    {w_carry, w_sum} = {1'b0, op1} + {1'b0, w_addB} + {{WIDTH{1'b0}}, w_isSub};
    if (w_isSub)
      w_ovf = (op1[MSB] != op2[MSB]) & (w_sum[MSB] != op1[MSB]);
    else
      w_ovf = (op1[MSB] == op2[MSB]) & (w_sum[MSB] != op1[MSB]);
    w_aluRes   = w_sum;
    w_aluArith = 1'b1;
    case (opcode)
      OP_AND: begin w_aluRes = op1 & op2; w_aluArith = 1'b0; end
      OP_ORR: begin w_aluRes = op1 | op2; w_aluArith = 1'b0; end
      OP_EOR: begin w_aluRes = op1 ^ op2; w_aluArith = 1'b0; end
      OP_MOV: begin w_aluRes = op2;       w_aluArith = 1'b0; end
      default: ;
    endcase
    w_aluWr = (opcode != OP_CMP);
  end

`ifdef ALU_PIPE_MUL_EN
  logic             r_busy;
  logic [CNT_W-1:0] r_mulCnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [TAG_W-1:0] r_mulTag;
  logic             r_mulSetCond;
  logic [WIDTH-1:0] w_accNext;
  logic             w_mulLast;
  logic             w_mulDone;
  logic             w_startMul;

  // The last partial product is folded in combinationally so the product can load on the WIDTH-th busy edge.
  assign w_accNext  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mulLast  = (r_mulCnt == CNT_W'(WIDTH - 1));
  assign w_mulDone  = r_busy & w_mulLast & w_outFree;
  assign w_startMul = w_accept & (opcode == OP_MUL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_mulCnt     <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_acc        <= '0;
      r_mulTag     <= '0;
      r_mulSetCond <= 1'b0;
    end else if (w_startMul) begin
      r_busy       <= 1'b1;
      r_mulCnt     <= '0;
      r_mcand      <= op1;
      r_mplier     <= op2;
      r_acc        <= '0;
      r_mulTag     <= in_tag;
      r_mulSetCond <= set_cond;
    end else if (r_busy) begin
      if (!w_mulLast) begin
        r_acc    <= w_accNext;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_mulCnt <= r_mulCnt + CNT_W'(1);
      end else if (w_outFree) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign w_busy      = r_busy;
  assign w_load      = (w_accept & !w_startMul) | w_mulDone;
  assign w_ldRes     = w_mulDone ? w_accNext : w_aluRes;
  assign w_ldTag     = w_mulDone ? r_mulTag : in_tag;
  assign w_ldWr      = w_mulDone ? 1'b1 : w_aluWr;
  assign w_ldSetCond = w_mulDone ? r_mulSetCond : set_cond;
  assign w_ldArith   = w_mulDone ? 1'b0 : w_aluArith;
`else
  assign w_busy      = 1'b0;
  assign w_load      = w_accept;
  assign w_ldRes     = w_aluRes;
  assign w_ldTag     = in_tag;
  assign w_ldWr      = w_aluWr;
  assign w_ldSetCond = set_cond;
  assign w_ldArith   = w_aluArith;
`endif

  // Result and flags load together; logical ops and MUL leave C and V untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_outTag   <= '0;
      r_outWr    <= 1'b0;
      r_n        <= 1'b0;
      r_z        <= 1'b0;
      r_c        <= 1'b0;
      r_v        <= 1'b0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_result   <= w_ldRes;
      r_outTag   <= w_ldTag;
      r_outWr    <= w_ldWr;
      if (w_ldSetCond) begin
        r_n <= w_ldRes[MSB];
        r_z <= (w_ldRes == '0);
        if (w_ldArith) begin
          r_c <= w_carry;
          r_v <= w_ovf;
        end
      end
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign result    = r_result;
  assign out_tag   = r_outTag;
  assign out_wr    = r_outWr;
  assign flag_n    = r_n;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign cond_eq   = r_z;
  assign cond_ne   = !r_z;
  assign cond_hi   = r_c & !r_z;
  assign cond_lt   = r_n != r_v;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized stimulus for alu_pipe, checked every cycle against a
// transaction-level model (expected-result queue plus NZCV chain); honours ALU_PIPE_MUL_EN.

module tb_alu_pipe;

  localparam int W  = 32;
  localparam int TW = 4;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    opcode = 4'b0000;
  logic          set_cond = 1'b0;
  logic [W-1:0]  op1 = '0;
  logic [W-1:0]  op2 = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [TW-1:0] out_tag;
  logic          out_wr;
  logic          flag_n, flag_z, flag_c, flag_v;
  logic          cond_eq, cond_ne, cond_hi, cond_lt;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit randReady  = 1'b0;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          wr;
    logic [3:0]    nzcv;
    int            readyCyc;
  } txn_t;

  txn_t       q[$];
  txn_t       t;
  logic [3:0] chainFlags = '0;
  logic [3:0] shownFlags = '0;
  bit         headShown  = 1'b0;
  bit         expValid;
  bit         mulBusy;
  bit         expReady;

  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .set_cond(set_cond),
    .op1(op1), .op2(op2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .out_wr(out_wr),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .cond_eq(cond_eq), .cond_ne(cond_ne), .cond_hi(cond_hi), .cond_lt(cond_lt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome from plain arithmetic: unsigned compare for borrow, signed range for overflow.
  function automatic txn_t modelOp(input logic [3:0] opc, input logic sc, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [TW-1:0] tag,
                                   input logic [3:0] flagsIn);
    txn_t         o;
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         c, v, arith;
    longint       sr, maxS, minS;
`ifdef ALU_PIPE_MUL_EN
    logic [2*W-1:0] p;
`endif
    maxS  = (longint'(1) <<< (W - 1)) - 1;
    minS  = -(longint'(1) <<< (W - 1));
    c     = flagsIn[1];
    v     = flagsIn[0];
    arith = 1'b1;
    case (opc)
      4'b0010, 4'b1010: begin
        r  = a - b;
        c  = (a >= b);
        sr = longint'($signed(a)) - longint'($signed(b));
        v  = (sr > maxS) || (sr < minS);
      end
      4'b1101: begin r = b;     arith = 1'b0; end
      4'b0000: begin r = a & b; arith = 1'b0; end
      4'b1100: begin r = a | b; arith = 1'b0; end
      4'b0001: begin r = a ^ b; arith = 1'b0; end
`ifdef ALU_PIPE_MUL_EN
      4'b0110: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = p[W-1:0];
        arith = 1'b0;
      end
`endif
      default: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[W-1:0];
        c    = wide[W];
        sr   = longint'($signed(a)) + longint'($signed(b));
        v    = (sr > maxS) || (sr < minS);
      end
    endcase
    o.res      = r;
    o.tag      = tag;
    o.wr       = (opc != 4'b1010);
    o.nzcv     = flagsIn;
    o.readyCyc = 0;
    if (sc) begin
      o.nzcv[3] = r[W-1];
      o.nzcv[2] = (r == '0);
      if (arith) o.nzcv[1:0] = {c, v};
    end
    return o;
  endfunction

  // Compare process: every falling edge, DUT outputs versus the model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        chainFlags = '0;
        shownFlags = '0;
        headShown  = 1'b0;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
      end else begin
        expValid = (q.size() > 0) && (q[0].readyCyc <= cyc);
        if (expValid && !headShown) begin
          shownFlags = q[0].nzcv;
          headShown  = 1'b1;
        end
        mulBusy  = (q.size() > 1) || ((q.size() == 1) && !expValid);
        expReady = !mulBusy && (!expValid || out_ready);
        checkOutput("out_valid", out_valid, expValid);
        checkOutput("in_ready", in_ready, expReady);
        checkOutput("flags_nzcv", {flag_n, flag_z, flag_c, flag_v}, shownFlags);
        checkOutput("conds", {cond_eq, cond_ne, cond_hi, cond_lt},
                    {shownFlags[2], !shownFlags[2], shownFlags[1] & !shownFlags[2],
                     shownFlags[3] != shownFlags[0]});
        if (expValid) begin
          checkOutput("result", result, q[0].res);
          checkOutput("out_tag", out_tag, q[0].tag);
          checkOutput("out_wr", out_wr, q[0].wr);
        end
        if (expValid && out_ready) begin
          q.delete(0);
          headShown = 1'b0;
        end
        if (in_valid && expReady) begin
          t = modelOp(opcode, set_cond, op1, op2, in_tag, chainFlags);
          t.readyCyc = cyc + ((MULEN && opcode == 4'b0110) ? W + 1 : 1);
          chainFlags = t.nzcv;
          q.push_back(t);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] opc, input logic sc, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [TW-1:0] tag);
    bit accepted;
    accepted = 1'b0;
    opcode   = opc;
    set_cond = sc;
    op1      = a;
    op2      = b;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 for 500 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    bit sawValid;
    $display("[TB] start, multiplier %s", MULEN ? "enabled" : "disabled");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_wr", out_wr, 0);
    checkOutput("reset_out_tag", out_tag, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // Signed overflow into the sign bit.
    applyStimulus(4'b0100, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 4'h3);
    checkOutput("add_ovf_result", result, 32'h8000_0000);
    checkOutput("add_ovf_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b1001);
    checkOutput("add_ovf_cond_lt", cond_lt, 0);

    applyStimulus(4'b1010, 1'b1, 32'd5, 32'd5, 4'h1);
    checkOutput("cmp_eq_wr", out_wr, 0);
    checkOutput("cmp_eq_result", result, 0);
    checkOutput("cmp_eq_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b0110);
    checkOutput("cmp_eq_eq_hi", {cond_eq, cond_hi}, 2'b10);
    applyStimulus(4'b1010, 1'b1, 32'd3, 32'd7, 4'h2);
    checkOutput("cmp_lt_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b1000);
    checkOutput("cmp_lt_cond_lt", cond_lt, 1);

    // MOV keeps C from the preceding SUB; an op without set_cond leaves flags alone.
    applyStimulus(4'b0010, 1'b1, 32'd9, 32'd2, 4'h4);
    checkOutput("sub_result", result, 32'd7);
    checkOutput("sub_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b0010);
    applyStimulus(4'b1101, 1'b1, 32'hDEAD_BEEF, 32'd0, 4'h5);
    checkOutput("mov0_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b0110);
    applyStimulus(4'b0001, 1'b0, 32'd5, 32'd3, 4'h6);
    checkOutput("eor_nosc_result", result, 32'd6);
    checkOutput("eor_nosc_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b0110);

    // Back-to-back stream with a three-cycle output stall in the middle.
    applyStimulus(4'b0100, 1'b0, 32'd1, 32'd1, 4'h1);
    applyStimulus(4'b0100, 1'b0, 32'd2, 32'd2, 4'h2);
    out_ready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    @(negedge clk);
    checkOutput("stall_result_held", result, 32'd4);
    checkOutput("stall_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    applyStimulus(4'b0100, 1'b0, 32'd3, 32'd3, 4'h3);
    applyStimulus(4'b0100, 1'b0, 32'd4, 32'd4, 4'h4);
    checkOutput("stream_last_result", result, 32'd8);
    checkOutput("stream_last_tag", out_tag, 4'h4);

`ifdef ALU_PIPE_MUL_EN
    applyStimulus(4'b0110, 1'b1, 32'h0001_0003, 32'h0002_0005, 4'h7);
    sawValid = 1'b0;
    repeat (W) begin
      if (out_valid || in_ready) sawValid = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput("mul_quiet_while_busy", sawValid, 0);
    checkOutput("mul_valid", out_valid, 1);
    checkOutput("mul_result", result, 32'h000B_000F);

    // Reset in the middle of a multiply discards it.
    applyStimulus(4'b0110, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 4'h8);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mul_rst_in_ready", in_ready, 1);
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("mul_rst_no_valid", sawValid, 0);
    @(posedge clk);
    #1;
`endif

    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), pickOperand(),
                    pickOperand(), TW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    randReady = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
    checkOutput("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
